instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Packs decoded fields (op, rd, rs1, rs2, imm) into 32-bit RV32 instruction words and streams them to instruction memory.
//  Inverse of the immediate generator: every legal word it emits decodes back to the same immediate.
//  Sits between the test-program loader and the instruction-memory write port.
//  Range-checks immediates, assigns sequential addresses and supports output backpressure.
// PARAMETERS
//  ADDR_W     8   word-address width of the instruction-memory write port
//  BASE_ADDR  0   first word address used after start_i
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       asynchronous, active-low reset
//  start_i      in   1       begin or restart a program: address reset to BASE_ADDR, err/full cleared
//  in_valid_i   in   1       input fields valid
//  in_ready_o   out  1       encoder accepts fields this cycle
//  op_i         in   3       0 ADDI, 1 SRAI, 2 LW, 3 SW, 4 BEQ; 5-7 are illegal
//  rd_i         in   5       destination register
//  rs1_i        in   5       source register 1
//  rs2_i        in   5       source register 2
//  imm_i        in   32      signed immediate (for BEQ: 12-bit halfword offset field)
//  out_valid_o  out  1       encoded word and address valid
//  out_ready_i  in   1       memory accepts the word
//  out_addr_o   out  ADDR_W  word address of out_data_o
//  out_data_o   out  32      encoded instruction
//  count_o      out  ADDR_W+1  number of words accepted by memory since start_i
//  full_o       out  1       last address issued; no further input accepted
//  err_o        out  1       sticky error flag
//  err_code_o   out  2       01 illegal op, 10 immediate out of range, 00 none
// BEHAVIOUR
//  Reset (rst_i=0, async): state IDLE; in_ready_o=0; out_valid_o=0; out_data_o=0; out_addr_o=BASE_ADDR;
//    count_o=0; full_o=0; err_o=0; err_code_o=0. Reset mid-transfer drops any pending word.
//  FSM IDLE -> RUN on start_i. RUN -> ERR on a rejected input. RUN -> FULL when address 2^ADDR_W-1 is accepted.
//    Any state -> RUN on start_i, which resets the address, count, err and full.
//  in_ready_o = (state==RUN) && !start_i && (!out_valid_o || out_ready_i).
//  Accept = in_valid_i && in_ready_o. An accepted legal input is registered: out_valid_o=1 the next cycle, latency 1.
//    The address counter increments after each accept and wraps into FULL, never back to 0.
//  Output handshake: out_data_o and out_addr_o stay stable while out_valid_o && !out_ready_i.
//    A transfer occurs when out_valid_o && out_ready_i. A simultaneous transfer and accept loads the new word with no bubble.
//    count_o increments on each transfer.
//  Encodings ({} is MSB..LSB):
//    ADDI {imm[11:0],rs1,3'b000,rd,7'b0010011}
//    SRAI {7'b0100000,imm[4:0],rs1,3'b101,rd,7'b0010011}
//    LW   {imm[11:0],rs1,3'b010,rd,7'b0000011}
//    SW   {imm[11:5],rs2,rs1,3'b010,imm[4:0],7'b0100011}
//    BEQ  {imm[11],imm[9:4],rs2,rs1,3'b000,imm[3:0],imm[10],7'b1100011}
//  Range rules (imm_i is 32-bit two's complement):
//    ADDI, LW, SW, BEQ: -2048..2047. SRAI: 0..31.
//    Outside the range -> err_code 10. op 5-7 -> err_code 01 (illegal op takes priority).
//  Rejected input: it is consumed (handshake completes), no word is emitted and the address is not advanced.
//    err_o=1 and err_code_o are set the next cycle; state goes to ERR with in_ready_o=0.
//  In ERR or FULL, a pending output word still drains normally.
//  start_i while a word is pending: the word still drains with its original address; count_o is cleared.
//    The transfer in that cycle is not counted.
//  start_i has priority over an accept in the same cycle; in_ready_o is 0 in that cycle.
// TESTING
//  1 start_i; ADDI rd=1 rs1=0 imm=5 -> next cycle out_valid_o=1, addr 0, data 0x00500093; count_o=1 after transfer.
//  2 SW rs2=2 rs1=3 imm=-4 -> 0xFE21AE23; SRAI rd=5 rs1=5 imm=3 -> 0x4032D293;
//    BEQ rs1=rs2=0 imm=-2 -> 0xFE000EE3; addresses 0,1,2 in order.
//  3 ADDI imm=2048 -> no out_valid_o, err_o=1, err_code_o=10, in_ready_o=0, address unchanged;
//    op=6 -> err_code_o=01; start_i clears both.
//  4 out_ready_i held 0 for 3 cycles with two valid inputs -> first word stable, in_ready_o=0;
//    release -> both words delivered back-to-back, count_o=2.
//  5 ADDR_W=2: five valid inputs -> four words at 0..3, full_o=1 after the 4th accept, 5th never accepted;
//    start_i -> next word at address 0.
//  6 rst_i low while out_valid_o=1 -> all outputs at reset values immediately; no transfer after release.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32 fields into instruction words and streams them,
// with immediate range checks, sequential addressing and output backpressure.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        op_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [31:0]       out_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);
    typedef enum logic [1:0] {IDLE, RUN, ERR, FULL} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] next_addr;
    logic              accept;
    logic              xfer;
    logic              illegal;
    logic              range_ok;
    logic [31:0]       enc;

    assign in_ready_o = (state == RUN) && !start_i && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign xfer       = out_valid_o && out_ready_i;
    assign illegal    = op_i > 3'd4;
    // 12-bit signed range means bits 31..11 are all sign copies
    assign range_ok   = (op_i == 3'd1) ? (imm_i[31:5] == 27'd0)
                                       : (&imm_i[31:11] || ~|imm_i[31:11]);

    always_comb begin
        enc = (op_i == 3'd0) ? {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b0010011} :
              (op_i == 3'd1) ? {7'b0100000, imm_i[4:0], rs1_i, 3'b101, rd_i, 7'b0010011} :
              (op_i == 3'd2) ? {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011} :
              (op_i == 3'd3) ? {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011} :
                               {imm_i[11], imm_i[9:4], rs2_i, rs1_i, 3'b000, imm_i[3:0], imm_i[10], 7'b1100011};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            next_addr   <= BASE;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_addr_o  <= BASE;
            count_o     <= '0;
            full_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= 2'b00;
        end else begin
            if (xfer) begin
                out_valid_o <= 1'b0;
                if (!start_i) count_o <= count_o + 1'b1;
            end
            // restart never touches a pending word; it drains with its own address
            if (start_i) begin
                state      <= RUN;
                next_addr  <= BASE;
                count_o    <= '0;
                full_o     <= 1'b0;
                err_o      <= 1'b0;
                err_code_o <= 2'b00;
            end else if (accept) begin
                if (illegal || !range_ok) begin
                    state      <= ERR;
                    err_o      <= 1'b1;
                    err_code_o <= illegal ? 2'b01 : 2'b10;
                end else begin
                    out_valid_o <= 1'b1;
                    out_data_o  <= enc;
                    out_addr_o  <= next_addr;
                    if (next_addr == LAST) begin
                        state  <= FULL;
                        full_o <= 1'b1;
                    end else begin
                        next_addr <= next_addr + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed bench with a scoreboard of expected words/addresses
// for a 4-word (ADDR_W=2) encoder.
module tb_instr_encoder;
    logic        clk = 0;
    logic        rst_i = 0;
    logic        start_i = 0;
    logic        in_valid_i = 0;
    logic        out_ready_i = 1;
    logic [2:0]  op_i = 0;
    logic [4:0]  rd_i = 0, rs1_i = 0, rs2_i = 0;
    logic [31:0] imm_i = 0;
    logic        in_ready_o, out_valid_o, full_o, err_o;
    logic [1:0]  out_addr_o, err_code_o;
    logic [31:0] out_data_o;
    logic [2:0]  count_o;

    typedef struct packed {logic [1:0] addr; logic [31:0] data;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int passed = 0, failed = 0, total = 0, exp_addr = 0;

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_addr_o(out_addr_o), .out_data_o(out_data_o),
        .count_o(count_o), .full_o(full_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_i && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                total++;
                failed++;
                $error("FAIL spurious_word observed=%h expected=none", out_data_o);
            end else begin
                mon_e = sb.pop_front();
                chk("word_data", out_data_o, mon_e.data);
                chk("word_addr", 32'(out_addr_o), 32'(mon_e.addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_i = 1;
        tick();
        start_i = 0;
        exp_addr = 0;
    endtask

    task automatic push(input logic [31:0] d);
        sb.push_back('{addr: 2'(exp_addr), data: d});
        exp_addr++;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input bit legal,
                        input logic [31:0] d);
        int n = 0;
        op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
        in_valid_i = 1;
        @(negedge clk);
        while (!in_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("accept_timeout", 32'(in_ready_o), 32'd1);
        else if (legal) push(d);
        tick();
        in_valid_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_data", out_data_o, 32'd0);
        chk("rst_addr", 32'(out_addr_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_code", 32'(err_code_o), 32'd0);
        tick();
        rst_i = 1;
        tick();
        // basic ADDI
        do_start();
        send(3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h00500093);
        @(negedge clk); chk("t1_valid", 32'(out_valid_o), 32'd1);
        tick();
        @(negedge clk); chk("t1_count", 32'(count_o), 32'd1);
        tick();
        // mixed formats, sequential addresses
        do_start();
        send(3'd3, 5'd0, 5'd3, 5'd2, -32'sd4, 1, 32'hFE21AE23);
        send(3'd1, 5'd5, 5'd5, 5'd0, 32'd3, 1, 32'h4032D293);
        send(3'd4, 5'd0, 5'd0, 5'd0, -32'sd2, 1, 32'hFE000EE3);
        repeat (2) tick();
        @(negedge clk);
        chk("t2_count", 32'(count_o), 32'd3);
        chk("t2_drained", 32'(sb.size()), 32'd0);
        tick();
        // range and illegal-op errors
        send(3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 32'd0);
        @(negedge clk);
        chk("t3_err", 32'(err_o), 32'd1);
        chk("t3_code_range", 32'(err_code_o), 32'd2);
        chk("t3_in_ready", 32'(in_ready_o), 32'd0);
        chk("t3_no_word", 32'(out_valid_o), 32'd0);
        chk("t3_addr_held", 32'(out_addr_o), 32'd2);
        tick();
        do_start();
        send(3'd6, 5'd1, 5'd0, 5'd0, 32'd0, 0, 32'd0);
        @(negedge clk);
        chk("t3_code_illegal", 32'(err_code_o), 32'd1);
        chk("t3_err2", 32'(err_o), 32'd1);
        tick();
        do_start();
        @(negedge clk);
        chk("t3_err_clr", 32'(err_o), 32'd0);
        chk("t3_code_clr", 32'(err_code_o), 32'd0);
        chk("t3_ready_again", 32'(in_ready_o), 32'd1);
        tick();
        send(3'd0, 5'd1, 5'd0, 5'd0, -32'sd2048, 1, 32'h80000093);
        send(3'd1, 5'd5, 5'd5, 5'd0, 32'd32, 0, 32'd0);
        @(negedge clk);
        chk("t3_srai_range", 32'(err_code_o), 32'd2);
        tick();
        // backpressure
        do_start();
        out_ready_i = 0;
        send(3'd0, 5'd2, 5'd0, 5'd0, 32'd1, 1, 32'h00100113);
        op_i = 3'd0; rd_i = 5'd3; rs1_i = 5'd1; imm_i = 32'hFFFFFFFF;
        in_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_ready", 32'(in_ready_o), 32'd0);
            chk("t4_stall_data", out_data_o, 32'h00100113);
            chk("t4_stall_valid", 32'(out_valid_o), 32'd1);
            tick();
        end
        out_ready_i = 1;
        @(negedge clk);
        chk("t4_release_ready", 32'(in_ready_o), 32'd1);
        push(32'hFFF08193);
        tick();
        in_valid_i = 0;
        @(negedge clk); chk("t4_second_valid", 32'(out_valid_o), 32'd1);
        tick();
        @(negedge clk); chk("t4_count", 32'(count_o), 32'd2);
        tick();
        // restart while a word is pending
        do_start();
        send(3'd0, 5'd1, 5'd0, 5'd0, 32'd7, 1, 32'h00700093);
        tick();
        @(negedge clk); chk("t7_count1", 32'(count_o), 32'd1);
        tick();
        out_ready_i = 0;
        send(3'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1, 32'h00800093);
        out_ready_i = 1;
        do_start();
        @(negedge clk);
        chk("t7_count_clr", 32'(count_o), 32'd0);
        chk("t7_drained", 32'(out_valid_o), 32'd0);
        tick();
        // fill all four addresses
        do_start();
        for (int i = 0; i < 4; i++)
            send(3'd0, 5'd1, 5'd0, 5'd0, 32'(i), 1, (32'(i) << 20) | 32'h93);
        @(negedge clk);
        chk("t5_full", 32'(full_o), 32'd1);
        chk("t5_full_ready", 32'(in_ready_o), 32'd0);
        tick();
        imm_i = 32'd4;
        in_valid_i = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_fifth_blocked", 32'(in_ready_o), 32'd0);
            tick();
        end
        in_valid_i = 0;
        @(negedge clk);
        chk("t5_count", 32'(count_o), 32'd4);
        tick();
        do_start();
        @(negedge clk); chk("t5_full_clr", 32'(full_o), 32'd0);
        tick();
        send(3'd0, 5'd1, 5'd0, 5'd0, 32'd9, 1, 32'h00900093);
        repeat (2) tick();
        @(negedge clk); chk("t5_drained", 32'(sb.size()), 32'd0);
        tick();
        // async reset with a pending word
        out_ready_i = 0;
        send(3'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1, 32'h00100093);
        rst_i = 0;
        #1;
        chk("t6_valid", 32'(out_valid_o), 32'd0);
        chk("t6_data", out_data_o, 32'd0);
        chk("t6_addr", 32'(out_addr_o), 32'd0);
        chk("t6_count", 32'(count_o), 32'd0);
        chk("t6_in_ready", 32'(in_ready_o), 32'd0);
        sb.delete();
        out_ready_i = 1;
        repeat (2) tick();
        rst_i = 1;
        repeat (3) tick();
        @(negedge clk); chk("t6_no_xfer", 32'(out_valid_o), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
